// File: rtl/uart_rx_hex.sv
// uart_rx_hex: receives 8N1 UART characters and decodes lines of the form
// "HH HH HH HH HH HH" followed by CR into six byte registers.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_res            synchronous active-high reset
//   i_rx_en          receive enable; low holds the receiver and parser idle
//   i_uart_rx        asynchronous serial input, idle high, LSB first
//   o_reg_1..o_reg_6 last valid decoded line (byte 1 is first on the wire)
//   o_valid          one-cycle pulse when o_reg_1..6 update
//   o_err            one-cycle pulse when a character or line is discarded
//
// Parameter CLK_DIV: i_clk cycles per UART bit.
// Optional feature macro UART_RX_HEX_LOWER_EN: when defined, hex positions also
// accept lowercase 'a'..'f'.
module uart_rx_hex #(
  parameter logic [12:0] CLK_DIV = 13'd4167
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_rx_en,
  input  logic       i_uart_rx,
  output logic [7:0] o_reg_1,
  output logic [7:0] o_reg_2,
  output logic [7:0] o_reg_3,
  output logic [7:0] o_reg_4,
  output logic [7:0] o_reg_5,
  output logic [7:0] o_reg_6,
  output logic       o_valid,
  output logic       o_err
);

  localparam int unsigned CNT_W    = 13;
  localparam int unsigned POS_W    = 5;
  localparam int unsigned NBYTES   = 6;
  localparam logic [POS_W-1:0] LAST_POS = 5'd17;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  // Sample points inside a bit: mid-start-bit, then every full bit period.
  localparam logic [CNT_W-1:0] HALF_LAST =
    (CLK_DIV < 13'd2) ? '0 : CNT_W'((CLK_DIV >> 1) - 13'd1);
  localparam logic [CNT_W-1:0] BIT_LAST =
    (CLK_DIV == 13'd0) ? '0 : CNT_W'(CLK_DIV - 13'd1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  // Two-flop synchronizer; idle level is high so both flops reset to 1.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-level receiver
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              char_done_c;
  logic              frame_err_c;

  // Receiver state register.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Receiver next-state and character strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = CNT_W'(cnt_q + 13'd1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    char_done_c = 1'b0;
    frame_err_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) begin
          state_d   = ST_START;
          bit_idx_d = '0;
        end
      end
      ST_START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = 3'(bit_idx_q + 3'd1);
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rx_sync_q) begin
            char_done_c = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    if (!i_rx_en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      char_done_c = 1'b0;
      frame_err_c = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Line parser
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0]         pos_q, pos_d;
  logic                     hunt_q, hunt_d;
  logic [NBYTES-1:0][7:0]   shadow_q, shadow_d;
  logic [NBYTES-1:0][7:0]   regs_q, regs_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic [2:0]               byte_idx_c;
  logic [1:0]               col_c;
  logic                     is_hex_c;
  logic [3:0]               nibble_c;

  // Position p maps to byte p/3; column 0/1 are hex digits, column 2 a space.
  assign byte_idx_c = 3'(pos_q / 5'd3);
  assign col_c      = 2'(pos_q - 5'(5'(byte_idx_c) * 5'd3));

`ifdef UART_RX_HEX_LOWER_EN
  assign is_hex_c = ((shift_q >= 8'h30) && (shift_q <= 8'h39)) ||
                    ((shift_q >= 8'h41) && (shift_q <= 8'h46)) ||
                    ((shift_q >= 8'h61) && (shift_q <= 8'h66));
`else
  assign is_hex_c = ((shift_q >= 8'h30) && (shift_q <= 8'h39)) ||
                    ((shift_q >= 8'h41) && (shift_q <= 8'h46));
`endif

  // Letters (bit 6 set) map 'A'/'a' = x1 to 10; digits use the low nibble.
  assign nibble_c = shift_q[6] ? 4'(shift_q[3:0] + 4'd9) : shift_q[3:0];

  // Parser state register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      pos_q    <= '0;
      hunt_q   <= 1'b0;
      shadow_q <= '0;
      regs_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      hunt_q   <= hunt_d;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Parser next-state: one decision per received character.
  always_comb begin
    pos_d    = pos_q;
    hunt_d   = hunt_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (frame_err_c) begin
      err_d  = 1'b1;
      hunt_d = 1'b1;
      pos_d  = '0;
    end else if (char_done_c) begin
      if (hunt_q) begin
        // Discard silently until a CR marks the start of the next line.
        if (shift_q == CH_CR) begin
          hunt_d = 1'b0;
          pos_d  = '0;
        end
      end else if (shift_q == CH_CR) begin
        // CR always resynchronises; only a complete line commits.
        pos_d = '0;
        if (pos_q == LAST_POS) begin
          regs_d  = shadow_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (pos_q == LAST_POS) begin
        err_d  = 1'b1;
        hunt_d = 1'b1;
      end else if (col_c == 2'd2) begin
        if (shift_q == CH_SP) begin
          pos_d = POS_W'(pos_q + 5'd1);
        end else begin
          err_d  = 1'b1;
          hunt_d = 1'b1;
        end
      end else if (is_hex_c) begin
        if (col_c == 2'd0) begin
          shadow_d[byte_idx_c][7:4] = nibble_c;
        end else begin
          shadow_d[byte_idx_c][3:0] = nibble_c;
        end
        pos_d = POS_W'(pos_q + 5'd1);
      end else begin
        err_d  = 1'b1;
        hunt_d = 1'b1;
      end
    end

    if (!i_rx_en) begin
      pos_d   = '0;
      hunt_d  = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  assign o_reg_1 = regs_q[0];
  assign o_reg_2 = regs_q[1];
  assign o_reg_3 = regs_q[2];
  assign o_reg_4 = regs_q[3];
  assign o_reg_5 = regs_q[4];
  assign o_reg_6 = regs_q[5];
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_uart_rx_hex.sv
// Directed bench for uart_rx_hex: table of whole lines plus hand-written
// sequences for framing error, glitch, enable drop and mid-byte reset.
module tb_uart_rx_hex;

  localparam logic [12:0] DIV = 13'd16;
  localparam int unsigned NDIV = 16;
  localparam int unsigned TXT_W = 18 * 8;
  localparam int unsigned NV = 12;

`ifdef UART_RX_HEX_LOWER_EN
  localparam int LC_V = 1;
  localparam int LC_E = 0;
  localparam logic [47:0] LC_REGS = 48'hABCDEF012345;
`else
  localparam int LC_V = 0;
  localparam int LC_E = 1;
  localparam logic [47:0] LC_REGS = 48'hFFEEDD001199;
`endif

  logic clk = 1'b0;
  logic res, rx_en, uart_rx;
  logic [7:0] reg_1, reg_2, reg_3, reg_4, reg_5, reg_6;
  logic valid, err;

  always #5 clk = ~clk;

  uart_rx_hex #(.CLK_DIV(DIV)) dut (
    .i_clk     (clk),
    .i_res     (res),
    .i_rx_en   (rx_en),
    .i_uart_rx (uart_rx),
    .o_reg_1   (reg_1),
    .o_reg_2   (reg_2),
    .o_reg_3   (reg_3),
    .o_reg_4   (reg_4),
    .o_reg_5   (reg_5),
    .o_reg_6   (reg_6),
    .o_valid   (valid),
    .o_err     (err)
  );

  typedef struct {
    logic [TXT_W-1:0] text;
    int               len;
    int               exp_valid;
    int               exp_err;
    logic [47:0]      exp_regs;
  } vec_t;

  vec_t vecs [NV];
  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (err === 1'b1) err_cnt++;
    if (valid === 1'b1 && err === 1'b1) both_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(NDIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(NDIV);
    end
    uart_rx = stop_bit;
    idle(NDIV);
    uart_rx = 1'b1;
    idle(2);
  endtask

  task automatic send_text(input logic [TXT_W-1:0] text, input int len);
    for (int i = 0; i < len; i++) begin
      send_byte(text[(len-1-i)*8 +: 8], 1'b1);
    end
  endtask

  task automatic send_line(input logic [TXT_W-1:0] text, input int len);
    send_text(text, len);
    send_byte(8'h0D, 1'b1);
    idle(4);
  endtask

  function automatic logic [47:0] regs_now();
    return {reg_1, reg_2, reg_3, reg_4, reg_5, reg_6};
  endfunction

  initial begin
    int v0, e0;

    vecs[0]  = '{"12 34 56 78 9A BC",  17, 1, 0, 48'h123456789ABC};
    vecs[1]  = '{"12 3G 56 78 9A BC",  17, 0, 1, 48'h123456789ABC};
    vecs[2]  = '{"01 02 03 04 05 06",  17, 1, 0, 48'h010203040506};
    vecs[3]  = '{"AB CD",               5, 0, 1, 48'h010203040506};
    vecs[4]  = '{"FF EE DD 00 11 99",  17, 1, 0, 48'hFFEEDD001199};
    vecs[5]  = '{"ab cd ef 01 23 45",  17, LC_V, LC_E, LC_REGS};
    vecs[6]  = '{"DE AD BE EF 00 42",  17, 1, 0, 48'hDEADBEEF0042};
    vecs[7]  = '{"12 34 56 78 9A BC ", 18, 0, 1, 48'hDEADBEEF0042};
    vecs[8]  = '{"@1 02 03 04 05 06",  17, 0, 1, 48'hDEADBEEF0042};
    vecs[9]  = '{"9: 02 03 04 05 06",  17, 0, 1, 48'hDEADBEEF0042};
    vecs[10] = '{"12,34 56 78 9A BC",  17, 0, 1, 48'hDEADBEEF0042};
    vecs[11] = '{"C0 FF EE 12 34 56",  17, 1, 0, 48'hC0FFEE123456};

    res = 1'b1;
    rx_en = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    check("reset_regs", 64'(regs_now()), 64'h0);
    check("reset_valid", 64'(valid), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    res = 1'b0;
    idle(10);

    for (int i = 0; i < int'(NV); i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_line(vecs[i].text, vecs[i].len);
      check($sformatf("vec%0d_valid", i), 64'(valid_cnt - v0), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_regs", i), 64'(regs_now()), 64'(vecs[i].exp_regs));
    end

    // Framing error: one o_err, next line consumed while hunting, then decode.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h31, 1'b0);
    idle(20);
    check("frame_err", 64'(err_cnt - e0), 64'd1);
    send_line("11 22 33 44 55 66", 17);
    check("frame_hunt_valid", 64'(valid_cnt - v0), 64'd0);
    check("frame_hunt_err", 64'(err_cnt - e0), 64'd1);
    send_line("21 43 65 87 A9 CB", 17);
    check("frame_next_valid", 64'(valid_cnt - v0), 64'd1);
    check("frame_next_regs", 64'(regs_now()), 64'h2143_6587_A9CB);

    // Short low glitch on the idle line is rejected at mid-start-bit.
    v0 = valid_cnt;
    e0 = err_cnt;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(60);
    check("glitch_valid", 64'(valid_cnt - v0), 64'd0);
    check("glitch_err", 64'(err_cnt - e0), 64'd0);
    check("glitch_regs", 64'(regs_now()), 64'h2143_6587_A9CB);

    // Dropping enable mid-line returns the parser to position 0.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_text("12 3", 4);
    rx_en = 1'b0;
    idle(10);
    rx_en = 1'b1;
    idle(5);
    send_line("5A A5 0F F0 00 FF", 17);
    check("en_valid", 64'(valid_cnt - v0), 64'd1);
    check("en_err", 64'(err_cnt - e0), 64'd0);
    check("en_regs", 64'(regs_now()), 64'h5AA5_0FF0_00FF);

    // Reset in the middle of a byte clears outputs without any pulse.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_text("34", 2);
    uart_rx = 1'b0;
    idle(NDIV);
    uart_rx = 1'b1;
    idle(NDIV * 2);
    res = 1'b1;
    idle(1);
    check("midreset_regs", 64'(regs_now()), 64'h0);
    res = 1'b0;
    uart_rx = 1'b1;
    idle(20);
    check("midreset_valid", 64'(valid_cnt - v0), 64'd0);
    check("midreset_err", 64'(err_cnt - e0), 64'd0);
    send_line("77 66 55 44 33 22", 17);
    check("after_reset_valid", 64'(valid_cnt - v0), 64'd1);
    check("after_reset_regs", 64'(regs_now()), 64'h7766_5544_3322);

    check("valid_err_overlap", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_hex.md
UART_RX_HEX -- requirements
Module: uart_rx_hex

Interface
REQ-001 SHALL have parameter CLK_DIV, default 13'd4167, meaning i_clk cycles per UART bit (40 MHz / 9600 bps).
REQ-002 SHALL have port i_clk  input  1  system clock, 40 MHz, all logic on rising edge.
REQ-003 SHALL have port i_res  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_rx_en  input  1  receive enable; low holds block idle.
REQ-005 SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have ports o_reg_1 .. o_reg_6  output  8 each  last valid decoded line, byte 1 first on the wire.
REQ-007 SHALL have port o_valid  output  1  one-cycle pulse when o_reg_1..6 update.
REQ-008 SHALL have port o_err  output  1  one-cycle pulse when a line or character is discarded.

Function
REQ-009 SHALL pass i_uart_rx through a 2-flop synchronizer, both flops resetting to 1; all decoding uses the synchronized value.
REQ-010 Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-011 IDLE: synchronized line low -> START with bit counter cleared.
REQ-012 START: after CLK_DIV/2 cycles, sample line; 0 -> DATA; 1 -> IDLE (glitch, no o_err).
REQ-013 DATA: sample every CLK_DIV cycles, 8 samples, shifted in LSB first -> STOP.
REQ-014 STOP: sample after CLK_DIV cycles; 1 -> character complete, IDLE; 0 -> framing error, o_err pulse, parser to HUNT, FSM to WAIT_HIGH.
REQ-015 WAIT_HIGH: remain until synchronized line is 1, then IDLE.
REQ-016 Parser holds char position 0..17 and mode SYNC/HUNT; line format is 17 chars plus CR: "HH HH HH HH HH HH" then 0x0D.
REQ-017 Positions 0,1,3,4,6,7,9,10,12,13,15,16 SHALL accept only 0x30-0x39 and 0x41-0x46, converted to nibble (high nibble first) into shadow registers.
REQ-018 Positions 2,5,8,11,14 SHALL accept only 0x20; position 17 SHALL accept only 0x0D.
REQ-019 0x0D at position 17: copy all six shadow bytes to o_reg_1..6 in the same cycle, o_valid high exactly 1 cycle, position to 0; latency 1 i_clk from the stop-bit sample.
REQ-020 Any other character at any position in SYNC: o_err pulse, mode HUNT; o_reg_1..6 unchanged.
REQ-021 0x0D received at a position other than 17 in SYNC: o_err pulse, position 0, mode stays SYNC (immediate resync).
REQ-022 HUNT: discard all characters without further o_err; 0x0D -> SYNC, position 0.
REQ-023 o_valid and o_err SHALL never be high in the same cycle; at most one pulse per character.
REQ-024 i_rx_en low: FSM IDLE, baud counter 0, position 0, mode SYNC, no pulses; o_reg_1..6 hold their value; rising i_rx_en starts in IDLE.
REQ-025 Baud counter SHALL be 13 bits and clear on every FSM state change; no wrap within a bit.

Reset
REQ-026 i_res high at a clock edge SHALL set o_reg_1..6 to 8'h00, o_valid 0, o_err 0, synchronizer flops 1, FSM IDLE, position 0, mode SYNC, shadow registers 0.
REQ-027 Reset mid-character or mid-line SHALL abort it with no o_valid or o_err pulse; reception restarts at the next start bit.
REQ-028 Reset SHALL take priority over i_rx_en.

Configuration
REQ-029 Macro UART_RX_HEX_LOWER_EN defined: hex positions SHALL also accept 0x61-0x66 as nibbles A-F.
REQ-030 Macro UART_RX_HEX_LOWER_EN undefined: 0x61-0x66 at hex positions SHALL be errors per REQ-020.

Verification
REQ-031 Send "12 34 56 78 9A BC\r" at 9600 bps -> one o_valid pulse, o_reg_1..6 = 12,34,56,78,9A,BC, no o_err.
REQ-032 Send "12 3G 56 78 9A BC\r" then "01 02 03 04 05 06\r" -> one o_err at 'G', regs hold old value; second line -> o_valid, regs 01..06.
REQ-033 Send byte 0x31 with stop bit forced 0, then valid line -> o_err once, FSM waits for line high; next line decoded correctly.
REQ-034 Send "AB CD\r" -> o_err at CR, no o_valid; following full line decoded with single o_valid.
REQ-035 1000-cycle low glitch on idle line -> no o_err, no o_valid; assert i_res mid-byte -> all outputs 0, next line decodes.
REQ-036 Send "ab cd ef 01 23 45\r" -> with UART_RX_HEX_LOWER_EN: o_valid, regs AB,CD,EF,01,23,45; without: o_err, no o_valid.
